// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the HI/LO multiply/divide unit.
package muldiv_pkg;

   localparam int unsigned MD_WIDTH = 32;
   localparam int unsigned MD_CNT_W = 6;
   localparam int unsigned MD_ITERS = MD_WIDTH;

   // Operation encodings presented on op; 6 and 7 decode as no-ops.
   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } md_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH:0]   rem_o,
   output logic             q_o
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] trial;

   // Trial subtract; a clear sign bit means the divisor fits.
   always_comb begin
      shifted = {rem_i, bit_i};
      trial   = shifted - {2'b00, divisor_i};
      q_o     = ~trial[WIDTH+1];
      rem_o   = q_o ? trial[WIDTH:0] : shifted[WIDTH:0];
   end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit owning the architectural HI/LO pair.
module hilo_muldiv
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = MD_ITERS,
   parameter int unsigned CNT_W = MD_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   md_state_t          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic               is_div_q, is_div_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               busy_q, busy_d, done_q, done_d;

   logic               issue_md_c, issue_mthi_c, issue_mtlo_c;
   logic               issue_div_c, issue_signed_c;
   logic               s1_c, s2_c, last_iter_c;
   logic [WIDTH-1:0]   mag1_c, mag2_c;
   logic [WIDTH-1:0]   mul_add_c;
   logic [WIDTH:0]     mul_sum_c;
   logic [2*WIDTH:0]   mul_acc_c, div_acc_c;
   logic [WIDTH:0]     div_rem_c;
   logic               div_q_c;
   logic [2*WIDTH-1:0] prod_c, prod_fix_c;
   logic [WIDTH-1:0]   quo_c, rem_c;

   // Issue decode; start is only honoured in IDLE.
   always_comb begin
      issue_md_c     = 1'b0;
      issue_mthi_c   = 1'b0;
      issue_mtlo_c   = 1'b0;
      issue_div_c    = 1'b0;
      issue_signed_c = 1'b0;
      if (start && (state_q == IDLE)) begin
         case (op)
            MD_MULT:  begin issue_md_c = 1'b1; issue_signed_c = 1'b1; end
            MD_MULTU: begin issue_md_c = 1'b1; end
            MD_DIV:   begin issue_md_c = 1'b1; issue_signed_c = 1'b1; issue_div_c = 1'b1; end
            MD_DIVU:  begin issue_md_c = 1'b1; issue_div_c = 1'b1; end
            MD_MTHI:  issue_mthi_c = 1'b1;
            MD_MTLO:  issue_mtlo_c = 1'b1;
            default:  ;
         endcase
      end
   end

   // Operand magnitudes; WIDTH-bit unsigned so the most negative value maps to 2^(WIDTH-1).
   always_comb begin
      s1_c   = issue_signed_c & op1[WIDTH-1];
      s2_c   = issue_signed_c & op2[WIDTH-1];
      mag1_c = s1_c ? (~op1 + WIDTH'(1)) : op1;
      mag2_c = s2_c ? (~op2 + WIDTH'(1)) : op2;
   end

   // LSB-first shift-add step: upper half accumulates, multiplier shifts out below.
   always_comb begin
      mul_add_c = acc_q[0] ? opb_q : '0;
      mul_sum_c = acc_q[2*WIDTH:WIDTH] + {1'b0, mul_add_c};
      mul_acc_c = {1'b0, mul_sum_c, acc_q[WIDTH-1:1]};
   end

   // Restoring divide: remainder in the upper WIDTH+1 bits, dividend/quotient below.
   div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_i     (acc_q[2*WIDTH:WIDTH]),
      .bit_i     (acc_q[WIDTH-1]),
      .divisor_i (opb_q),
      .rem_o     (div_rem_c),
      .q_o       (div_q_c)
   );

   assign div_acc_c = {div_rem_c, acc_q[WIDTH-2:0], div_q_c};

   // Sign correction applied in FIX.
   always_comb begin
      prod_c     = acc_q[2*WIDTH-1:0];
      prod_fix_c = neg_res_q ? (~prod_c + (2*WIDTH)'(1)) : prod_c;
      quo_c      = acc_q[WIDTH-1:0];
      rem_c      = acc_q[2*WIDTH-1:WIDTH];
   end

   assign last_iter_c = (cnt_q == CNT_W'(WIDTH - 1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (issue_md_c) state_d = RUN;
         RUN:     if (last_iter_c) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode: busy follows the next state, done marks the FIX exit.
   always_comb begin
      busy_d = (state_d != IDLE);
      done_d = (state_q == FIX);
   end

   // Datapath next-state: operand capture, iteration, result write-back.
   always_comb begin
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opb_d     = opb_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         IDLE: begin
            if (issue_md_c) begin
               cnt_d     = '0;
               acc_d     = {(WIDTH+1)'(0), mag1_c};
               opb_d     = mag2_c;
               is_div_d  = issue_div_c;
               neg_res_d = s1_c ^ s2_c;
               neg_rem_d = s1_c;
            end
            if (issue_mthi_c) hi_d = op1;
            if (issue_mtlo_c) lo_d = op1;
         end
         RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            acc_d = is_div_q ? div_acc_c : mul_acc_c;
         end
         FIX: begin
            if (is_div_q) begin
               lo_d = neg_res_q ? (~quo_c + WIDTH'(1)) : quo_c;
               hi_d = neg_rem_q ? (~rem_c + WIDTH'(1)) : rem_c;
            end else begin
               hi_d = prod_fix_c[2*WIDTH-1:WIDTH];
               lo_d = prod_fix_c[WIDTH-1:0];
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         opb_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opb_q     <= opb_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed vector bench for hilo_muldiv.
module tb_hilo_muldiv;
   import muldiv_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] op1, op2;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_vec;
   int n_err;

   hilo_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .op1   (op1),
      .op2   (op2),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  vop;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ehi;
      logic [31:0] elo;
      string       name;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one op from posedge+1 with busy low; returns the edge index of done.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int done_edge, output int busy_cnt, output logic held);
      logic [31:0] h0, l0;
      h0 = hi;
      l0 = lo;
      start = 1'b1; op = o; op1 = a; op2 = b;
      @(posedge clk); #1;
      start = 1'b0;
      done_edge = -1;
      busy_cnt  = 0;
      held      = 1'b1;
      if (busy) busy_cnt++;
      for (int k = 1; k <= 60 && done_edge < 0; k++) begin
         @(posedge clk); #1;
         if (done) done_edge = k;
         else if (hi !== h0 || lo !== l0) held = 1'b0;
         if (busy) busy_cnt++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int   de, bc, k;
      logic hd, saw_done;

      n_vec = 0;
      n_err = 0;

      vecs[0]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
      vecs[1]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg3x7"};
      vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7d2"};
      vecs[3]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"};
      vecs[4]  = '{MD_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, "divu_by0"};
      vecs[5]  = '{MD_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'h00000001, "div_neg_by0"};
      vecs[6]  = '{MD_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, "div_pos_by0"};
      vecs[7]  = '{MD_DIVU,  32'd1000,     32'd7,        32'd6,        32'd142,      "divu_1000d7"};
      vecs[8]  = '{MD_MULT,  32'hFFFFFFFC, 32'hFFFFFFFB, 32'h00000000, 32'h00000014, "mult_negxneg"};
      vecs[9]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7dneg2"};
      vecs[10] = '{MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, "multu_2p32"};
      vecs[11] = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, "divu_max_d16"};
      vecs[12] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_min_sq"};

      // Reset state
      rst_n = 1'b0; start = 1'b0; op = 3'd0; op1 = '0; op2 = '0;
      #1;
      chk("rst.busy", {31'd0, busy}, 32'd0);
      chk("rst.done", {31'd0, done}, 32'd0);
      chk("rst.hi", hi, 32'd0);
      chk("rst.lo", lo, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // MTHI / MTLO at idle
      start = 1'b1; op = MD_MTHI; op1 = 32'h12345678;
      @(posedge clk); #1;
      start = 1'b0;
      chk("mthi.hi", hi, 32'h12345678);
      chk("mthi.busy", {31'd0, busy}, 32'd0);
      chk("mthi.done", {31'd0, done}, 32'd0);
      start = 1'b1; op = MD_MTLO; op1 = 32'hCAFEF00D;
      @(posedge clk); #1;
      start = 1'b0;
      chk("mtlo.lo", lo, 32'hCAFEF00D);
      chk("mtlo.hi_kept", hi, 32'h12345678);

      // Table of full multiply/divide operations
      for (int i = 0; i < 13; i++) begin
         run_op(vecs[i].vop, vecs[i].a, vecs[i].b, de, bc, hd);
         chk($sformatf("%s.done_edge", vecs[i].name), 32'(de), 32'd33);
         chk($sformatf("%s.busy_cycles", vecs[i].name), 32'(bc), 32'd33);
         chk($sformatf("%s.hold", vecs[i].name), {31'd0, hd}, 32'd1);
         chk($sformatf("%s.hi", vecs[i].name), hi, vecs[i].ehi);
         chk($sformatf("%s.lo", vecs[i].name), lo, vecs[i].elo);
         @(posedge clk); #1;
         chk($sformatf("%s.done_width", vecs[i].name), {31'd0, done}, 32'd0);
      end

      // Issues while busy are ignored; issue in the done cycle is accepted
      start = 1'b1; op = MD_DIVU; op1 = 32'd1000; op2 = 32'd7;
      @(posedge clk); #1;
      k = 0;
      while (!done && k < 60) begin
         start = 1'b1;
         op    = (k % 2 == 0) ? MD_MULTU : MD_MTLO;
         op1   = 32'd9;
         op2   = 32'd3;
         @(posedge clk); #1;
         k++;
      end
      chk("ign.done_edge", 32'(k), 32'd33);
      chk("ign.lo", lo, 32'd142);
      chk("ign.hi", hi, 32'd6);
      start = 1'b1; op = MD_MULTU; op1 = 32'd9; op2 = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b.busy", {31'd0, busy}, 32'd1);
      chk("b2b.done", {31'd0, done}, 32'd0);
      k = 0;
      while (!done && k < 60) begin
         @(posedge clk); #1;
         k++;
      end
      chk("b2b.done_edge", 32'(k), 32'd33);
      chk("b2b.hi", hi, 32'd0);
      chk("b2b.lo", lo, 32'd27);
      @(posedge clk); #1;

      // Reset mid-operation
      start = 1'b1; op = MD_MTHI; op1 = 32'h0000AAAA;
      @(posedge clk); #1;
      op = MD_MTLO; op1 = 32'h0000BBBB;
      @(posedge clk); #1;
      start = 1'b0;
      chk("pre.hi", hi, 32'h0000AAAA);
      chk("pre.lo", lo, 32'h0000BBBB);
      start = 1'b1; op = MD_MULTU; op1 = 32'd5; op2 = 32'd6;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("arst.busy", {31'd0, busy}, 32'd0);
      chk("arst.done", {31'd0, done}, 32'd0);
      chk("arst.hi", hi, 32'd0);
      chk("arst.lo", lo, 32'd0);
      saw_done = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || busy) saw_done = 1'b1;
      end
      chk("arst.no_done", {31'd0, saw_done}, 32'd0);
      run_op(MD_MULTU, 32'd5, 32'd6, de, bc, hd);
      chk("post.done_edge", 32'(de), 32'd33);
      chk("post.hi", hi, 32'd0);
      chk("post.lo", lo, 32'd30);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
